// File: rtl/mips_hazard_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller.
//   FWD_*   : forwarding-select encodings for the Execute operand muxes
//   state_t : imem wait-state FSM encoding
//   REGW    : register-index width
//   reg_hit : source/destination match that never fires on register $0
package mips_pipe_pkg;

   localparam int REGW = 5;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic {RUN, IWAIT} state_t;

   // $0 is hard-wired to zero, so a write to it must never be forwarded or stalled on
   function automatic logic reg_hit(logic [REGW-1:0] src, logic [REGW-1:0] dst);
      return (src != '0) && (src == dst);
   endfunction

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives register indices / enables, receives controls
//   slave  : hazard controller side
interface mips_hazard_ctrl_if;
   import mips_pipe_pkg::*;

   logic [REGW-1:0] RsD, RtD, RsE, RtE;
   logic [REGW-1:0] WriteRegE, WriteRegM, WriteRegW;
   logic            RegWriteE, RegWriteM, RegWriteW;
   logic            MemtoRegE, MemtoRegM;
   logic            BranchD, PCSrcD, JumpD;
   logic            MdStartE, HiLoRdD, ImemRdyF;

   logic            StallF, StallD, FlushD, FlushE;
   logic            ForwardAD, ForwardBD;
   logic [1:0]      ForwardAE, ForwardBE;
   logic            MdBusy;

   modport master (
      output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
             BranchD, PCSrcD, JumpD, MdStartE, HiLoRdD, ImemRdyF,
      input  StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
             ForwardAE, ForwardBE, MdBusy
   );

   modport slave (
      input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
             RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
             BranchD, PCSrcD, JumpD, MdStartE, HiLoRdD, ImemRdyF,
      output StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD,
             ForwardAE, ForwardBE, MdBusy
   );

endinterface

// File: rtl/mips_hazard_ctrl_fwd_unit.sv
// mips_fwd_unit: combinational forwarding selects.
//   in  : RsD, RtD, RsE, RtE, WriteRegM/W, RegWriteM/W
//   out : ForwardAE/BE (00 RF, 01 W, 10 M; M has priority), ForwardAD/BD (from M)
module mips_fwd_unit
   import mips_pipe_pkg::*;
(
   input  logic [REGW-1:0] RsD,
   input  logic [REGW-1:0] RtD,
   input  logic [REGW-1:0] RsE,
   input  logic [REGW-1:0] RtE,
   input  logic [REGW-1:0] WriteRegM,
   input  logic [REGW-1:0] WriteRegW,
   input  logic            RegWriteM,
   input  logic            RegWriteW,
   output logic [1:0]      ForwardAE,
   output logic [1:0]      ForwardBE,
   output logic            ForwardAD,
   output logic            ForwardBD
);

   // M holds the younger result, so it wins over W
   function automatic logic [1:0] fwd_sel(logic [REGW-1:0] src, logic [REGW-1:0] wm,
                                          logic rwm, logic [REGW-1:0] ww, logic rww);
      if (rwm && reg_hit(src, wm))      return FWD_M;
      else if (rww && reg_hit(src, ww)) return FWD_W;
      else                              return FWD_RF;
   endfunction

   assign ForwardAE = fwd_sel(RsE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
   assign ForwardBE = fwd_sel(RtE, WriteRegM, RegWriteM, WriteRegW, RegWriteW);
   assign ForwardAD = RegWriteM && reg_hit(RsD, WriteRegM);
   assign ForwardBD = RegWriteM && reg_hit(RtD, WriteRegM);

endmodule

// File: rtl/mips_hazard_ctrl.sv
// mips_hazard_ctrl: stall / flush / forwarding controller for the 5-stage pipeline.
//   FTODFF_CLK : clock, rising edge
//   FTODFF_RST : asynchronous active-low reset; all controls read 0 while low
//   hif        : slave side of mips_hazard_ctrl_if (hazard inputs, control outputs)
// Optional build macro HAZ_PERF_CNT_EN adds saturating 32-bit outputs
//   HzStallCnt (cycles with a stall hazard), HzFlushCnt (cycles FlushD=1),
//   ImissCnt (cycles ImemRdyF=0).
module mips_hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int MD_LAT  = 8,
   parameter int MDCNT_W = 4
)(
   input  logic        FTODFF_CLK,
   input  logic        FTODFF_RST,
   mips_hazard_ctrl_if.slave hif
`ifdef HAZ_PERF_CNT_EN
  ,output logic [31:0] HzStallCnt,
   output logic [31:0] HzFlushCnt,
   output logic [31:0] ImissCnt
`endif
);

   state_t             state;
   logic [MDCNT_W-1:0] mdcnt;
   logic               lwstall, brstall, mdstall, hz, imiss, flush_d;
   logic [1:0]         fwd_ae, fwd_be;
   logic               fwd_ad, fwd_bd;

   mips_fwd_unit u_fwd (
      .RsD       (hif.RsD),
      .RtD       (hif.RtD),
      .RsE       (hif.RsE),
      .RtE       (hif.RtE),
      .WriteRegM (hif.WriteRegM),
      .WriteRegW (hif.WriteRegW),
      .RegWriteM (hif.RegWriteM),
      .RegWriteW (hif.RegWriteW),
      .ForwardAE (fwd_ae),
      .ForwardBE (fwd_be),
      .ForwardAD (fwd_ad),
      .ForwardBD (fwd_bd)
   );

   assign lwstall = hif.MemtoRegE &&
                    (reg_hit(hif.RsD, hif.WriteRegE) || reg_hit(hif.RtD, hif.WriteRegE));
   // Decode compares need final values; an E-stage ALU result or M-stage load is not ready
   assign brstall = hif.BranchD &&
                    ((hif.RegWriteE && (reg_hit(hif.RsD, hif.WriteRegE) ||
                                        reg_hit(hif.RtD, hif.WriteRegE))) ||
                     (hif.MemtoRegM && (reg_hit(hif.RsD, hif.WriteRegM) ||
                                        reg_hit(hif.RtD, hif.WriteRegM))));
   assign mdstall = hif.HiLoRdD && ((mdcnt != '0) || hif.MdStartE);
   assign hz      = lwstall || brstall || mdstall;
   assign imiss   = !hif.ImemRdyF;
   // A held Decode stage must keep its instruction, so hz suppresses every flush source
   assign flush_d = !hz && (hif.PCSrcD || hif.JumpD || imiss);

   // Reset gates every output combinationally so controls drop the moment reset asserts
   assign hif.StallF    = FTODFF_RST && (hz || imiss);
   assign hif.StallD    = FTODFF_RST && hz;
   assign hif.FlushD    = FTODFF_RST && flush_d;
   assign hif.FlushE    = FTODFF_RST && hz;
   assign hif.ForwardAD = FTODFF_RST && fwd_ad;
   assign hif.ForwardBD = FTODFF_RST && fwd_bd;
   assign hif.ForwardAE = FTODFF_RST ? fwd_ae : FWD_RF;
   assign hif.ForwardBE = FTODFF_RST ? fwd_be : FWD_RF;
   assign hif.MdBusy    = FTODFF_RST && (mdcnt != '0);

   // Imem wait-state tracking; stall/flush follow ImemRdyF directly so no latency is added
   always_ff @(posedge FTODFF_CLK or negedge FTODFF_RST) begin
      if (!FTODFF_RST) begin
         state <= RUN;
      end else begin
         case (state)
            RUN:     if (imiss)  state <= IWAIT;
            IWAIT:   if (!imiss) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // MULT/DIV busy window: a new issue reloads even while a previous one is in flight
   always_ff @(posedge FTODFF_CLK or negedge FTODFF_RST) begin
      if (!FTODFF_RST)          mdcnt <= '0;
      else if (hif.MdStartE)    mdcnt <= MDCNT_W'(MD_LAT - 1);
      else if (mdcnt != '0)     mdcnt <= mdcnt - MDCNT_W'(1);
   end

`ifdef HAZ_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge FTODFF_CLK or negedge FTODFF_RST) begin
      if (!FTODFF_RST) begin
         HzStallCnt <= '0;
         HzFlushCnt <= '0;
         ImissCnt   <= '0;
      end else begin
         if (hz)      HzStallCnt <= sat_inc(HzStallCnt);
         if (flush_d) HzFlushCnt <= sat_inc(HzFlushCnt);
         if (imiss)   ImissCnt   <= sat_inc(ImissCnt);
      end
   end
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed testbench for mips_hazard_ctrl; expected control vectors are hand-computed.
// Vector packing: {StallF,StallD,FlushD,FlushE, ForwardAD,ForwardBD, ForwardAE, ForwardBE, MdBusy}
module tb_mips_hazard_ctrl;
   import mips_pipe_pkg::*;

   logic FTODFF_CLK = 1'b0;
   logic FTODFF_RST = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 FTODFF_CLK = ~FTODFF_CLK;

   mips_hazard_ctrl_if hif ();

   mips_hazard_ctrl #(.MD_LAT(8), .MDCNT_W(4)) dut (
      .FTODFF_CLK (FTODFF_CLK),
      .FTODFF_RST (FTODFF_RST),
      .hif        (hif)
   );

   function automatic logic [10:0] outs();
      return {hif.StallF, hif.StallD, hif.FlushD, hif.FlushE,
              hif.ForwardAD, hif.ForwardBD, hif.ForwardAE, hif.ForwardBE, hif.MdBusy};
   endfunction

   task automatic chk(input string tag, input logic [10:0] exp);
      logic [10:0] obs;
      #1;
      obs = outs();
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic clr_inputs();
      hif.RsD = '0; hif.RtD = '0; hif.RsE = '0; hif.RtE = '0;
      hif.WriteRegE = '0; hif.WriteRegM = '0; hif.WriteRegW = '0;
      hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
      hif.MemtoRegE = 0; hif.MemtoRegM = 0;
      hif.BranchD = 0; hif.PCSrcD = 0; hif.JumpD = 0;
      hif.MdStartE = 0; hif.HiLoRdD = 0; hif.ImemRdyF = 1;
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge FTODFF_CLK);
      #2;
   endtask

   initial begin
      clr_inputs();
      // reset held: hazards present on inputs, outputs still forced low
      hif.ImemRdyF = 0; hif.MemtoRegE = 1; hif.WriteRegE = 8; hif.RsD = 8;
      hif.RegWriteM = 1; hif.WriteRegM = 8; hif.RsE = 8;
      #3;
      chk("reset_outs", 11'b0000_00_00_00_0);
      cyc();
      clr_inputs();
      FTODFF_RST = 1;
      chk("idle", 11'b0000_00_00_00_0);

      // load-use stall, then the load moves to M and is forwarded
      cyc(); hif.MemtoRegE = 1; hif.WriteRegE = 8; hif.RsD = 8;
      chk("lwstall", 11'b1101_00_00_00_0);
      cyc(); clr_inputs(); hif.RsD = 8; hif.RsE = 8;
      hif.MemtoRegM = 1; hif.RegWriteM = 1; hif.WriteRegM = 8;
      chk("lw_after", 11'b0000_10_10_00_0);

      // register $0 never matches
      cyc(); clr_inputs(); hif.MemtoRegE = 1; hif.WriteRegE = 0; hif.RegWriteM = 1;
      hif.WriteRegM = 0; hif.RegWriteW = 1; hif.WriteRegW = 0;
      chk("reg0", 11'b0000_00_00_00_0);

      // Execute forwarding priority
      cyc(); clr_inputs(); hif.RegWriteM = 1; hif.WriteRegM = 5;
      hif.RegWriteW = 1; hif.WriteRegW = 5; hif.RsE = 5; hif.RtE = 5;
      chk("fwd_m", 11'b0000_00_10_10_0);
      hif.WriteRegM = 0;
      chk("fwd_w", 11'b0000_00_01_01_0);
      hif.WriteRegW = 0;
      chk("fwd_rf", 11'b0000_00_00_00_0);

      // branch compare stall with PCSrcD=1 must not flush
      cyc(); clr_inputs(); hif.BranchD = 1; hif.PCSrcD = 1; hif.RsD = 3;
      hif.RegWriteE = 1; hif.WriteRegE = 3;
      chk("brstall_e", 11'b1101_00_00_00_0);
      cyc(); hif.RegWriteE = 0; hif.WriteRegE = 0; hif.RegWriteM = 1; hif.WriteRegM = 3;
      chk("br_taken", 11'b0010_10_00_00_0);
      cyc(); clr_inputs(); hif.BranchD = 1; hif.RtD = 4;
      hif.MemtoRegM = 1; hif.RegWriteM = 1; hif.WriteRegM = 4;
      chk("brstall_m", 11'b1101_01_00_00_0);
      cyc(); clr_inputs(); hif.JumpD = 1;
      chk("jump", 11'b0010_00_00_00_0);

      // MULT/DIV busy window
      cyc(); clr_inputs(); hif.MdStartE = 1; hif.HiLoRdD = 1;
      chk("md_start", 11'b1101_00_00_00_0);
      for (int i = 1; i < 8; i++) begin
         cyc(); hif.MdStartE = 0;
         chk($sformatf("md_busy%0d", i), 11'b1101_00_00_00_1);
      end
      cyc();
      chk("md_done", 11'b0000_00_00_00_0);

      // imem misses
      for (int i = 0; i < 3; i++) begin
         cyc(); clr_inputs(); hif.ImemRdyF = 0;
         chk($sformatf("imiss%0d", i), 11'b1010_00_00_00_0);
      end
      cyc(); hif.ImemRdyF = 1;
      chk("imem_rdy", 11'b0000_00_00_00_0);
      cyc(); hif.ImemRdyF = 0; hif.MemtoRegE = 1; hif.WriteRegE = 9; hif.RtD = 9;
      chk("imiss_lw", 11'b1101_00_00_00_0);

      // reset dropped in the middle of an MD stall
      cyc(); clr_inputs(); hif.MdStartE = 1; hif.HiLoRdD = 1;
      chk("md2_start", 11'b1101_00_00_00_0);
      cyc(); hif.MdStartE = 0;
      chk("md2_busy", 11'b1101_00_00_00_1);
      FTODFF_RST = 0;
      chk("rst_mid", 11'b0000_00_00_00_0);
      cyc();
      FTODFF_RST = 1;
      chk("rst_release", 11'b0000_00_00_00_0);
      cyc();
      chk("post_rst", 11'b0000_00_00_00_0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
